// File: rtl/cadss_xfer_pkg.sv
// Shared types for the cache-transfer initiator: bus request types, request
// record and FSM state encoding.
package cadss_xfer_pkg;

  localparam int XFER_ADDR_W = 64;
  localparam int XFER_PROC_W = 4;

  typedef enum logic [2:0] {
    BUSRD  = 3'd0,
    BUSWR  = 3'd1,
    DATA   = 3'd2,
    SHARED = 3'd3,
    MEMORY = 3'd4
  } brt_e;

  // brt is kept as raw bits so encodings 5-7 travel through untouched
  typedef struct packed {
    logic [2:0]             brt;
    logic [XFER_ADDR_W-1:0] addr;
    logic [XFER_PROC_W-1:0] src;
    logic [XFER_PROC_W-1:0] dst;
  } xfer_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/cadss_xfer_fifo.sv
// Synchronous request FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module cadss_xfer_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cadss_xfer_initiator.sv
// Cache-side transfer requester: buffers cache requests, issues one at a time
// to the interconnect and reports completion by done pulse or local timeout.
//
// state | meaning
// IDLE  | nothing outstanding; pops the FIFO head when one is buffered
// ISSUE | ic_valid held with current request until ic_ready
// WAIT  | accepted; timer runs until ic_done or the timeout boundary
// DONE  | one-cycle cmp_valid with registered qualifiers
module cadss_xfer_initiator
  import cadss_xfer_pkg::*;
#(
  parameter  int ADDR_W     = 64,
  parameter  int PROC_W     = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int TIMEOUT    = 1023,
  parameter  int TMR_W      = 10,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_brt,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [PROC_W-1:0] req_src,
  input  logic [PROC_W-1:0] req_dst,
  output logic              ic_valid,
  input  logic              ic_ready,
  output logic [2:0]        ic_brt,
  output logic [ADDR_W-1:0] ic_addr,
  output logic [PROC_W-1:0] ic_src,
  output logic [PROC_W-1:0] ic_dst,
  input  logic              ic_done,
  output logic              cmp_valid,
  output logic              cmp_timeout,
  output logic              cmp_local,
  output logic [ADDR_W-1:0] cmp_addr,
  output logic [PROC_W-1:0] cmp_src,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int REQ_W = 3 + ADDR_W + 2 * PROC_W;

  logic [REQ_W-1:0]  w_wr_data;
  logic [REQ_W-1:0]  w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [2:0]        w_head_brt;
  logic [ADDR_W-1:0] w_head_addr;
  logic [PROC_W-1:0] w_head_src;
  logic [PROC_W-1:0] w_head_dst;
  logic              w_head_local;
  logic              w_tmr_tc;

  xfer_state_e       r_state;
  xfer_state_e       w_state_nxt;
  logic [2:0]        r_cur_brt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [PROC_W-1:0] r_cur_src;
  logic [PROC_W-1:0] r_cur_dst;
  logic [TMR_W-1:0]  r_timer;
  logic              r_cmp_timeout;
  logic              r_cmp_local;

  // ready depends only on stored count, so a same-cycle pop cannot raise it
  assign req_ready = ~w_full;
  assign w_push    = req_valid & ~w_full;
  assign w_wr_data = {req_brt, req_addr, req_src, req_dst};

  cadss_xfer_fifo #(
    .DATA_W (REQ_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .i_push    (w_push),
    .i_wr_data (w_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign {w_head_brt, w_head_addr, w_head_src, w_head_dst} = w_head;
  assign w_head_local = (w_head_src == w_head_dst);
  assign w_tmr_tc     = (r_timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_local ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: if (ic_ready) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (ic_done || w_tmr_tc) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // done has priority over the timeout boundary when both land together
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cur_brt     <= '0;
      r_cur_addr    <= '0;
      r_cur_src     <= '0;
      r_cur_dst     <= '0;
      r_timer       <= '0;
      r_cmp_timeout <= 1'b0;
      r_cmp_local   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur_brt     <= w_head_brt;
        r_cur_addr    <= w_head_addr;
        r_cur_src     <= w_head_src;
        r_cur_dst     <= w_head_dst;
        r_cmp_local   <= w_head_local;
        r_cmp_timeout <= 1'b0;
      end
      if (r_state == ST_ISSUE && ic_ready) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer + 1'b1;
        if (!ic_done && w_tmr_tc) r_cmp_timeout <= 1'b1;
      end
    end
  end

  assign ic_valid    = (r_state == ST_ISSUE);
  assign ic_brt      = r_cur_brt;
  assign ic_addr     = r_cur_addr;
  assign ic_src      = r_cur_src;
  assign ic_dst      = r_cur_dst;
  assign cmp_valid   = (r_state == ST_DONE);
  assign cmp_timeout = r_cmp_timeout;
  assign cmp_local   = r_cmp_local;
  assign cmp_addr    = r_cur_addr;
  assign cmp_src     = r_cur_src;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cadss_xfer_initiator.sv
// Scoreboard bench for cadss_xfer_initiator: expected issues/completions are
// queued at stimulus time and popped by an interconnect responder and a
// completion monitor.
module tb_cadss_xfer_initiator;
  import cadss_xfer_pkg::*;

  localparam int AW = 64;
  localparam int PW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_brt = '0;
  logic [AW-1:0] req_addr = '0;
  logic [PW-1:0] req_src = '0;
  logic [PW-1:0] req_dst = '0;
  logic          ic_valid;
  logic          ic_ready = 1'b0;
  logic [2:0]    ic_brt;
  logic [AW-1:0] ic_addr;
  logic [PW-1:0] ic_src;
  logic [PW-1:0] ic_dst;
  logic          ic_done = 1'b0;
  logic          cmp_valid;
  logic          cmp_timeout;
  logic          cmp_local;
  logic [AW-1:0] cmp_addr;
  logic [PW-1:0] cmp_src;
  logic          busy;
  logic [2:0]    fifo_count;

  cadss_xfer_initiator #(
    .ADDR_W(AW), .PROC_W(PW), .FIFO_DEPTH(4), .TIMEOUT(TO), .TMR_W(5)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_brt(req_brt),
    .req_addr(req_addr), .req_src(req_src), .req_dst(req_dst),
    .ic_valid(ic_valid), .ic_ready(ic_ready), .ic_brt(ic_brt),
    .ic_addr(ic_addr), .ic_src(ic_src), .ic_dst(ic_dst), .ic_done(ic_done),
    .cmp_valid(cmp_valid), .cmp_timeout(cmp_timeout), .cmp_local(cmp_local),
    .cmp_addr(cmp_addr), .cmp_src(cmp_src), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit to;
    int at;
  } to_t;

  xfer_req_t cmp_q[$];
  xfer_req_t ic_q[$];
  to_t       to_q[$];

  // interconnect responder controls
  int rdy_mode = 1;   // 0 stall, 1 always ready, 2 random
  int forced_d = -1;  // done delay after accept; -1 picks at random
  bit stray_en = 1'b0;
  bit outst = 1'b0;
  int acc_at = 0;
  int dly = 0;

  always @(negedge clk) begin : responder
    bit        dn;
    xfer_req_t r;
    to_t       tq;
    if (!rst_l) begin
      ic_ready = 1'b0;
      ic_done  = 1'b0;
    end else begin
      dn = 1'b0;
      if (outst && cyc == acc_at + dly) begin
        dn    = 1'b1;
        outst = 1'b0;
      end else if (!outst && stray_en && $urandom_range(0, 5) == 0) begin
        dn = 1'b1;
      end
      ic_done = dn;
      case (rdy_mode)
        0:       ic_ready = 1'b0;
        1:       ic_ready = 1'b1;
        default: ic_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (ic_valid && ic_ready) begin
        acc_at = cyc + 1;
        dly    = (forced_d >= 0) ? forced_d : int'($urandom_range(0, 20));
        outst  = 1'b1;
        if (ic_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got addr 0x%0h, expected no issue (cycle %0d)", ic_addr, cyc);
        end else begin
          r = ic_q.pop_front();
          chk("ic_brt", 64'(ic_brt), 64'(r.brt));
          chk("ic_addr", ic_addr, r.addr);
          chk("ic_src", 64'(ic_src), 64'(r.src));
          chk("ic_dst", 64'(ic_dst), 64'(r.dst));
        end
        tq.to = (dly >= TO);
        tq.at = acc_at + ((dly < TO - 1) ? dly : TO - 1) + 1;
        to_q.push_back(tq);
      end
    end
  end

  always @(negedge clk) begin : cmp_monitor
    xfer_req_t e;
    to_t       t;
    if (rst_l && cmp_valid) begin
      if (cmp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_cmp: got addr 0x%0h, expected no completion (cycle %0d)", cmp_addr, cyc);
      end else begin
        e = cmp_q.pop_front();
        chk("cmp_addr", cmp_addr, e.addr);
        chk("cmp_src", 64'(cmp_src), 64'(e.src));
        chk("cmp_local", 64'(cmp_local), 64'(e.src == e.dst));
        if (e.src == e.dst) begin
          chk("cmp_timeout_local", 64'(cmp_timeout), 64'd0);
        end else if (to_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cmp_without_accept: got completion addr 0x%0h, expected an accepted issue first", cmp_addr);
        end else begin
          t = to_q.pop_front();
          chk("cmp_timeout", 64'(cmp_timeout), 64'(t.to));
          chk("cmp_cycle", 64'(cyc), 64'(t.at));
        end
      end
    end
  end

  // call at a negedge; returns at the negedge right after the push edge
  task automatic push_req(input logic [2:0] b, input logic [63:0] a,
                          input logic [3:0] s, input logic [3:0] d, output int at);
    xfer_req_t r;
    r.brt = b; r.addr = a; r.src = s; r.dst = d;
    req_valid = 1'b1;
    req_brt = b; req_addr = a; req_src = s; req_dst = d;
    for (int k = 0; k < 500 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got req_ready 0, expected 1 within 500 cycles");
      req_valid = 1'b0;
      at = -1;
      return;
    end
    at = cyc + 1;
    cmp_q.push_back(r);
    if (s != d) ic_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int lim);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (!busy && fifo_count == 0 && cmp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: got no end of test, expected finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p;
    int s;
    int d;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ic_valid", 64'(ic_valid), 64'd0);
    chk("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    rst_l = 1'b1;
    @(negedge clk);

    // single transfer, done 5 cycles after accept
    rdy_mode = 1; forced_d = 5;
    push_req(3'(BUSRD), 64'h1000, 4'd1, 4'd2, p);
    req_valid = 1'b0;
    chk("t1_ic_valid_early", 64'(ic_valid), 64'd0);
    @(negedge clk);
    chk("t1_ic_valid_latency", 64'(ic_valid), 64'd1);
    wait_idle("t1_drain", 200);

    // backpressure: one in ISSUE, four buffered
    rdy_mode = 0; forced_d = -1;
    for (int i = 0; i < 5; i++) push_req(3'(BUSWR), 64'h2000 + 64'(i), 4'd1, 4'd2, p);
    req_valid = 1'b0;
    chk("t2_req_ready_full", 64'(req_ready), 64'd0);
    chk("t2_fifo_count_full", 64'(fifo_count), 64'd4);
    for (int i = 0; i < 20; i++) begin
      chk("t2_stall_ic_valid", 64'(ic_valid), 64'd1);
      chk("t2_stall_ic_addr", ic_addr, 64'h2000);
      @(negedge clk);
    end
    rdy_mode = 1;
    wait_idle("t2_drain", 500);

    // timeout with late done that must be ignored
    forced_d = 20;
    push_req(3'd5, 64'hDEAD_BEEF_0000_0040, 4'd2, 4'd7, p);
    req_valid = 1'b0;
    wait_idle("t3_drain", 200);
    repeat (10) @(negedge clk);
    chk("t3_late_done_ignored", 64'(busy), 64'd0);

    // done on the timeout boundary cycle
    forced_d = TO - 1;
    push_req(3'(SHARED), 64'h3000, 4'd4, 4'd5, p);
    req_valid = 1'b0;
    wait_idle("t4_drain", 200);

    // local bypass
    push_req(3'(DATA), 64'h4000, 4'd3, 4'd3, p);
    req_valid = 1'b0;
    chk("t5_cmp_early", 64'(cmp_valid), 64'd0);
    @(negedge clk);
    chk("t5_cmp_valid", 64'(cmp_valid), 64'd1);
    chk("t5_ic_valid", 64'(ic_valid), 64'd0);
    wait_idle("t5_drain", 50);

    // reset in the middle of WAIT
    forced_d = 1000;
    push_req(3'(MEMORY), 64'h5000, 4'd6, 4'd1, p);
    req_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (busy && !ic_valid && !cmp_valid) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t6_in_wait", 64'(busy && !ic_valid && !cmp_valid), 64'd1);
    rst_l = 1'b0;
    #1;
    chk("t6_rst_ic_valid", 64'(ic_valid), 64'd0);
    chk("t6_rst_cmp_valid", 64'(cmp_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
    chk("t6_rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("t6_rst_ic_addr", ic_addr, 64'd0);
    chk("t6_rst_cmp_qual", 64'({cmp_timeout, cmp_local}), 64'd0);
    cmp_q.delete(); ic_q.delete(); to_q.delete();
    outst = 1'b0; forced_d = -1;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    chk("t6_no_cmp_after_rst", 64'(cmp_valid), 64'd0);

    // stream of 10 through a 4-deep FIFO exercises pointer wrap
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) begin
      s = int'($urandom_range(0, 15));
      d = (i % 4 == 3) ? s : int'($urandom_range(0, 15));
      push_req(3'($urandom_range(0, 7)), 64'h6000 + 64'(i), 4'(s), 4'(d), p);
    end
    req_valid = 1'b0;
    wait_idle("t6_stream_drain", 1500);

    // randomized traffic with stray done pulses
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(0, 15));
      push_req(3'($urandom_range(0, 7)), {$urandom(), $urandom()}, 4'(s), 4'(d), p);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_idle("rand_drain", 4000);
    chk("final_queues_empty", 64'(ic_q.size() + to_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
